mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DEPTH, 1024, number of 32-bit words in the shared unified memory; word addresses 0..DEPTH-1.
REQ-002 Port: Clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: Rst_n  in  1  reset, synchronous and active-low.
REQ-004 Port: I_Req  in  1  instruction-fetch requester read request, held high until I_Ack.
REQ-005 Port: I_Address  in  32  instruction word address.
REQ-006 Port: I_Ack  out  1  one-cycle pulse marking I-transaction completion.
REQ-007 Port: I_RData  out  32  read data for the I requester, valid when I_Ack=1.
REQ-008 Port: D_Req  in  1  data requester request, held high until D_Ack.
REQ-009 Port: D_Address  in  32  data word address.
REQ-010 Port: D_WriteEnable  in  1  1=store, 0=load.
REQ-011 Port: D_WriteData  in  32  store data.
REQ-012 Port: D_Ack  out  1  one-cycle pulse marking D-transaction completion.
REQ-013 Port: D_RData  out  32  load data, valid when D_Ack=1.
REQ-014 Port: Err  out  1  one-cycle pulse with the Ack of an out-of-range transaction.
REQ-015 Port: Mem_Address  out  32  address driven to the memory.
REQ-016 Port: Mem_WriteData  out  32  write data driven to the memory.
REQ-017 Port: Mem_WriteEnable  out  1  write strobe to the memory (memory writes on rising Clk).
REQ-018 Port: Mem_Data  in  32  combinational read data from the memory.
REQ-019 Port: Busy  out  1  high whenever state is not IDLE.
REQ-020 Port: Grant  out  1  owner of current transaction: 0=I, 1=D; held through ACCESS and DONE.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, DONE; transitions IDLE->ACCESS when I_Req|D_Req, ACCESS->DONE unconditionally, DONE->IDLE unconditionally.
REQ-022 On IDLE->ACCESS the block SHALL latch owner, address, write enable and write data; requester inputs are ignored until the next IDLE.
REQ-023 Arbitration SHALL be round-robin: sole requester wins; on simultaneous requests the requester not served last wins; LastGrant updates on every grant.
REQ-024 In ACCESS, Mem_Address/Mem_WriteData SHALL show latched values and Mem_WriteEnable = latched WE & owner=D & in-range & Rst_n.
REQ-025 In IDLE and DONE, Mem_WriteEnable SHALL be 0 and Mem_Address/Mem_WriteData SHALL hold the last latched values.
REQ-026 At the ACCESS->DONE edge, Mem_Data SHALL be registered into the owner's RData (0 if out-of-range); the other requester's RData is unchanged.
REQ-027 In DONE, the owner's Ack SHALL be 1 for exactly one cycle; a store also pulses D_Ack and leaves D_RData as the pre-write memory word.
REQ-028 Latency: request sampled at edge E -> memory access during cycle E+1 -> Ack high during cycle E+2; issue rate one transaction per 3 cycles.
REQ-029 Address >= DEPTH SHALL suppress the write, return RData=0 and pulse Err with the Ack.
REQ-030 A requester that keeps Req high through DONE SHALL be treated as a new request in the following IDLE cycle (subject to round-robin).
REQ-031 I requester SHALL never cause a write regardless of any input.

Reset
REQ-032 When Rst_n=0 at a rising edge: state=IDLE, LastGrant=D (so I wins the first conflict), Grant=0, I_Ack=D_Ack=Err=0, I_RData=D_RData=0, Mem_Address=Mem_WriteData=0.
REQ-033 Reset asserted during ACCESS SHALL abort the transaction: no memory write in that cycle, no Ack ever issued for it.

Verification
REQ-034 Single load: mem[2]=1, D_Req=1, D_Address=2, WE=0 at edge 0 -> D_Ack=1 and D_RData=1 in cycle 2, Busy=1 in cycles 1-2.
REQ-035 Store then load: D store 32'hAC040006 to addr 6, then load addr 6 -> D_RData=32'hAC040006, Mem_WriteEnable high exactly one cycle.
REQ-036 Conflict after reset: I_Req (addr 128) and D_Req (addr 0) held together -> I served first (I_RData=mem[128]), D second, then alternating I,D,I.
REQ-037 Out-of-range: D store to address 1024 -> no memory change, D_Ack=1 with Err=1, D_RData=0.
REQ-038 Reset mid-operation: D store to addr 5 with Rst_n=0 during ACCESS -> mem[5] unchanged, no D_Ack, all outputs at reset values next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter in front of a single-port
// unified memory; round-robin grant, one transaction per three cycles.
module mem_arbiter #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        I_Req,
  input  logic [31:0] I_Address,
  output logic        I_Ack,
  output logic [31:0] I_RData,
  input  logic        D_Req,
  input  logic [31:0] D_Address,
  input  logic        D_WriteEnable,
  input  logic [31:0] D_WriteData,
  output logic        D_Ack,
  output logic [31:0] D_RData,
  output logic        Err,
  output logic [31:0] Mem_Address,
  output logic [31:0] Mem_WriteData,
  output logic        Mem_WriteEnable,
  input  logic [31:0] Mem_Data,
  output logic        Busy,
  output logic        Grant
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 1 = D was served last
  logic        grant_q, grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        err_q, err_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        in_range;
  logic        pick_d;

  assign in_range = (addr_q < DEPTH_W);

  // On a conflict the requester that was not served last wins.
  assign pick_d = D_Req & (~I_Req | ~last_grant_q);

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned
    // and infers a latch; the pulse outputs default to 0 rather than hold.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    err_d        = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (I_Req | D_Req) begin
          state_d      = ACCESS;
          grant_d      = pick_d;
          last_grant_d = pick_d;
          addr_d       = pick_d ? D_Address : I_Address;
          wdata_d      = pick_d ? D_WriteData : 32'd0;
          we_d         = pick_d & D_WriteEnable;
        end
      end
      ACCESS: begin
        state_d = DONE;
        err_d   = ~in_range;
        if (grant_q) begin
          d_ack_d   = 1'b1;
          d_rdata_d = in_range ? Mem_Data : 32'd0;
        end else begin
          i_ack_d   = 1'b1;
          i_rdata_d = in_range ? Mem_Data : 32'd0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // independent of statement order.
    if (!Rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      we_q         <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      err_q        <= 1'b0;
      i_rdata_q    <= 32'd0;
      d_rdata_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      err_q        <= err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Rst_n gates the strobe directly so a reset during ACCESS blocks the write
  // at the very edge that would have committed it.
  assign Mem_WriteEnable = (state_q == ACCESS) & we_q & grant_q & in_range & Rst_n;
  assign Mem_Address     = addr_q;
  assign Mem_WriteData   = wdata_q;
  assign I_Ack           = i_ack_q;
  assign D_Ack           = d_ack_q;
  assign Err             = err_q;
  assign I_RData         = i_rdata_q;
  assign D_RData         = d_rdata_q;
  assign Busy            = (state_q != IDLE);
  assign Grant           = grant_q;

endmodule
